reload_counter: RTL

RELOAD_COUNTER -- requirements
Module: reload_counter

---
 rtl/reload_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/reload_counter.sv
// Up/down counter with a reload register, auto-reload or one-shot terminal behaviour.
// Optional count prescaler enabled by defining RELOAD_CNT_PRESCALE_EN.
module reload_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic             at_term;

`ifdef RELOAD_CNT_PRESCALE_EN
    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] presc_q, presc_d;

    // A step happens only on the cycle the prescaler wraps.
    assign tick = (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        presc_d = presc_q;
        if (load_i) begin
            presc_d = '0;
        end else if (state_q == RUN && en_i) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick            = 1'b1;
`endif

    assign at_term = up_i ? (count_q == '1) : (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (load_i) begin
            rld_d   = load_val_i;
            count_d = load_val_i;
            state_d = RUN;
        end else if (state_q == RUN && en_i && tick) begin
            if (at_term) begin
                count_d = rld_q;
                tc_d    = 1'b1;
                if (mode_i) begin
                    state_d = HALT;
                end
            end else if (up_i) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = (state_q == RUN);

endmodule
